ex_mux: RTL and testbench
=========================

# ex_mux

Registered 5-way operand/result selector for the execute (EX) stage. Each cycle it samples five WIDTH-bit candidate values and a 3-bit select. It registers the chosen value, a valid flag and an illegal-select flag, and presents them to the next pipeline stage one clock later. Downstream stalls freeze the output register.

## Interface

Parameters:
- WIDTH, 32, data width of every candidate input and of `out`.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clears all registers immediately.
- i0  input  WIDTH  candidate 0.
- i1  input  WIDTH  candidate 1.
- i2  input  WIDTH  candidate 2.
- i3  input  WIDTH  candidate 3.
- i4  input  WIDTH  candidate 4.
- control  input  3  select code; 0..4 choose i0..i4; 5..7 are illegal.
- in_valid  input  1  current inputs are a real pipeline slot.
- stall  input  1  downstream stall; when 1, all output registers hold.
- out  output  WIDTH  registered selected value.
- out_valid  output  1  registered copy of `in_valid` for the slot in `out`.
- sel_err  output  1  registered flag: the slot in `out` used an illegal select (5..7) while valid.

## Operation

- Combinational select:
  - control=0 → i0; 1 → i1; 2 → i2; 3 → i3; 4 → i4.
  - control=5, 6 or 7 → all-zeros.
- Illegal-select flag: `illegal = in_valid & (control > 4)`.
- Clock edge with rst_n=1 and stall=0:
  - out ← selected value.
  - out_valid ← in_valid.
  - sel_err ← illegal.
- Clock edge with stall=1: out, out_valid and sel_err keep their previous values. Inputs presented that cycle are dropped; the upstream stage must hold them.
- `out` is loaded from the select even when in_valid=0, so no bubble masking is applied to the data. out_valid=0 marks such slots.
- sel_err is never set when in_valid=0, whatever the value of control.
- No arithmetic; pure selection. Width is preserved, with no extension or truncation.

## Timing

- Latency: exactly 1 clock from input sampling to output.
- Throughput: one selection per clock when stall=0.
- Reset:
  - rst_n=0 clears out=0, out_valid=0, sel_err=0 asynchronously, without waiting for clk. This holds mid-operation and during a stall.
  - Release is synchronous in effect: the first capture occurs on the first rising edge with rst_n=1.
- Simultaneous events:
  - Reset dominates stall; stall dominates capture.
  - control changing in the same cycle as stall deasserting: the value present at that edge is captured.
- No combinational path from any input to any output.

## Structure

- Shared package `ex_mux_pkg`:
  - select-code localparams `SEL_I0=3'd0` … `SEL_I4=3'd4` and `SEL_MAX=3'd4`.
  - default WIDTH constant (32).
- Natural sub-module: `ex_mux_sel`, a purely combinational 5:1 selector plus illegal-code detect. The parent `ex_mux` holds the stall-gated output registers, the valid pipeline bit and async reset.

## Test plan

Common setup: i0=0, i1=1, i2=2, i3=3, i4=4, in_valid=1, stall=0.

- Sweep: control stepped 0,1,2,3,4 on successive cycles → out = 0,1,2,3,4 one clock later each step; out_valid=1 and sel_err=0 throughout.
- Illegal codes: control=5, then 6, then 7 → out=0 and sel_err=1 one clock later; with in_valid=0, control=7 → out=0, out_valid=0, sel_err=0.
- Stall:
  - With out=3 (control=3), assert stall and drive control=1 for 3 cycles → out stays 3, out_valid stays 1.
  - Deassert stall → out=1 on the next edge.
- Async reset mid-stream: with out=4, pull rst_n low between clock edges → out=0, out_valid=0, sel_err=0 immediately, without a clock edge. On release with control=2 → out=2 after the first rising edge.
- Full-width data: i3=32'hDEAD_BEEF, i4=32'hFFFF_FFFF, control=3 then 4 → out=32'hDEAD_BEEF, then 32'hFFFF_FFFF, with no bit loss.
- Bubble: in_valid=0, control=2 → out=2 and out_valid=0; next cycle in_valid=1 → out_valid=1.

Source files
------------

// File: rtl/ex_mux_pkg.sv
// ex_mux_pkg: shared constants for the EX-stage result selector.
//   WIDTH_DEFAULT - default candidate/result data width
//   SEL_I0..SEL_I4 - legal select codes; SEL_MAX is the highest legal code
package ex_mux_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [2:0] SEL_I0  = 3'd0;
    localparam logic [2:0] SEL_I1  = 3'd1;
    localparam logic [2:0] SEL_I2  = 3'd2;
    localparam logic [2:0] SEL_I3  = 3'd3;
    localparam logic [2:0] SEL_I4  = 3'd4;
    localparam logic [2:0] SEL_MAX = 3'd4;

endpackage

// File: rtl/ex_mux_sel.sv
// ex_mux_sel: purely combinational 5:1 selector with illegal-code detect.
//   i0..i4   - candidate values
//   control  - select code, 0..4 legal, 5..7 illegal (select all-zeros)
//   in_valid - slot qualifier; illegal is only flagged for real slots
//   sel_data - selected candidate
//   illegal  - in_valid and control above SEL_MAX
module ex_mux_sel
    import ex_mux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [2:0]       control,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sel_data,
    output logic             illegal
);

    always_comb begin
        sel_data = '0;
        case (control)
            SEL_I0:  sel_data = i0;
            SEL_I1:  sel_data = i1;
            SEL_I2:  sel_data = i2;
            SEL_I3:  sel_data = i3;
            SEL_I4:  sel_data = i4;
            default: sel_data = '0;
        endcase
    end

    assign illegal = in_valid & (control > SEL_MAX);

endmodule

// File: rtl/ex_mux.sv
// ex_mux: registered 5-way operand/result selector for the EX stage.
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset, clears all outputs
//   i0..i4    - candidate values
//   control   - select code (0..4 legal, 5..7 illegal)
//   in_valid  - inputs are a real pipeline slot
//   stall     - downstream stall, holds all output registers
//   out       - registered selected value (loaded even for bubbles)
//   out_valid - registered in_valid
//   sel_err   - registered illegal-select flag for a valid slot
module ex_mux
    import ex_mux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [2:0]       control,
    input  logic             in_valid,
    input  logic             stall,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sel_err
);

    logic [WIDTH-1:0] sel_data;
    logic             illegal;

    ex_mux_sel #(
        .WIDTH(WIDTH)
    ) u_sel (
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .i4      (i4),
        .control (control),
        .in_valid(in_valid),
        .sel_data(sel_data),
        .illegal (illegal)
    );

    // Stall holds everything; inputs offered during a stall are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else if (!stall) begin
            out       <= sel_data;
            out_valid <= in_valid;
            sel_err   <= illegal;
        end
    end

endmodule

// File: tb/tb_ex_mux.sv
module tb_ex_mux;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] i0, i1, i2, i3, i4;
    logic [2:0]   control;
    logic         in_valid;
    logic         stall;
    logic [W-1:0] out;
    logic         out_valid;
    logic         sel_err;

    int total;
    int bad;

    ex_mux #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0       (i0),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .i4       (i4),
        .control  (control),
        .in_valid (in_valid),
        .stall    (stall),
        .out      (out),
        .out_valid(out_valid),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the output register must hold, from the rules.
    logic [W-1:0] m_out;
    logic         m_valid;
    logic         m_err;

    function automatic logic [W-1:0] pick(input logic [2:0] c, input logic [W-1:0] a0,
                                          input logic [W-1:0] a1, input logic [W-1:0] a2,
                                          input logic [W-1:0] a3, input logic [W-1:0] a4);
        logic [W-1:0] cand [5];
        cand = '{a0, a1, a2, a3, a4};
        if (int'(c) < 5) return cand[c];
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= '0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else if (!stall) begin
            m_out   <= pick(control, i0, i1, i2, i3, i4);
            m_valid <= in_valid;
            m_err   <= in_valid && (int'(control) >= 5);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("model.out", out, m_out);
        check("model.out_valid", W'(out_valid), W'(m_valid));
        check("model.sel_err", W'(sel_err), W'(m_err));
    endtask

    // Compare against the model mid-cycle, then land at posedge+1 for driving.
    task automatic tick();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [W-1:0] e_out,
                             input logic e_valid, input logic e_err);
        check({name, ".out"}, out, e_out);
        check({name, ".out_valid"}, W'(out_valid), W'(e_valid));
        check({name, ".sel_err"}, W'(sel_err), W'(e_err));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        i0 = 32'd0; i1 = 32'd1; i2 = 32'd2; i3 = 32'd3; i4 = 32'd4;
        control  = 3'd0;
        in_valid = 1'b1;
        stall    = 1'b0;

        #2;
        check_all("reset", 32'd0, 1'b0, 1'b0);
        #5 rst_n = 1'b1;                 // released at t=7, first capture at t=15
        tick();

        // Sweep legal codes
        for (int c = 0; c < 5; c++) begin
            control = 3'(c);
            tick();
            check_all($sformatf("sweep%0d", c), W'(c), 1'b1, 1'b0);
        end

        // Illegal codes
        for (int c = 5; c < 8; c++) begin
            control = 3'(c);
            tick();
            check_all($sformatf("illegal%0d", c), 32'd0, 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        control  = 3'd7;
        tick();
        check_all("illegal_bubble", 32'd0, 1'b0, 1'b0);

        // Stall holds the output
        in_valid = 1'b1;
        control  = 3'd3;
        tick();
        check_all("pre_stall", 32'd3, 1'b1, 1'b0);
        stall   = 1'b1;
        control = 3'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all($sformatf("stall%0d", k), 32'd3, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick();
        check_all("unstall", 32'd1, 1'b1, 1'b0);

        // Async reset between edges
        control = 3'd4;
        tick();
        check_all("pre_reset", 32'd4, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 32'd0, 1'b0, 1'b0);
        control = 3'd2;
        @(negedge clk);
        cmp_model();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 32'd2, 1'b1, 1'b0);

        // Full-width data
        i3      = 32'hDEAD_BEEF;
        i4      = 32'hFFFF_FFFF;
        control = 3'd3;
        tick();
        check_all("wide3", 32'hDEAD_BEEF, 1'b1, 1'b0);
        control = 3'd4;
        tick();
        check_all("wide4", 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Bubble still loads data
        in_valid = 1'b0;
        control  = 3'd2;
        tick();
        check_all("bubble", 32'd2, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        check_all("after_bubble", 32'd2, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            i0       = $urandom();
            i1       = $urandom();
            i2       = $urandom();
            i3       = $urandom();
            i4       = $urandom();
            control  = 3'($urandom_range(0, 7));
            in_valid = 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                check_all("rand_reset", 32'd0, 1'b0, 1'b0);
                #1 rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
